pattern_writer: RTL



---
 rtl/pattern_writer_pkg.sv | 59 +++++
 rtl/lfsr16_galois.sv | 42 ++++
 rtl/pattern_writer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pattern_writer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : pattern_writer_pkg                                               |
// | Shared constants and types for the pattern block memory: seven-segment     |
// | direction glyphs (digit3..digit0, active-low), direction code enum, LFSR   |
// | seed/mask, and the pattern_writer state encoding.                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package pattern_writer_pkg;

  localparam int          GLYPH_W      = 28;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_MASK    = 16'hB400;

  // Glyph images as stored in the pattern RAM; gameplay compares and
  // displays these same words.
  localparam logic [GLYPH_W-1:0] GLYPH_UP   = 28'b1000001000110011111111111111;
  localparam logic [GLYPH_W-1:0] GLYPH_DOWN = 28'b1000000100000010101011001000;
  localparam logic [GLYPH_W-1:0] GLYPH_LEFT = 28'b1000111000011000011100000111;
  localparam logic [GLYPH_W-1:0] GLYPH_RITE = 28'b1001100111100100001110000110;
  localparam logic [GLYPH_W-1:0] GLYPH_MID  = 28'b1101010111100110000001111111;

  typedef enum logic [2:0] {
    DIR_UP   = 3'd0,
    DIR_DOWN = 3'd1,
    DIR_LEFT = 3'd2,
    DIR_RITE = 3'd3,
    DIR_MID  = 3'd4
  } dir_code_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GEN    = 3'd1,
    S_VERIFY = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } pw_state_e;

  // Only codes 0..4 map to a direction; 5..7 are discarded draws.
  function automatic logic code_is_valid(input logic [2:0] code);
    return (code <= DIR_MID);
  endfunction

  function automatic logic [GLYPH_W-1:0] glyph_of(input logic [2:0] code);
    logic [GLYPH_W-1:0] g;
    g = '0;
    case (code)
      DIR_UP:   g = GLYPH_UP;
      DIR_DOWN: g = GLYPH_DOWN;
      DIR_LEFT: g = GLYPH_LEFT;
      DIR_RITE: g = GLYPH_RITE;
      DIR_MID:  g = GLYPH_MID;
      default:  g = '0;
    endcase
    return g;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16_galois.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : lfsr16_galois                                                    |
// | 16-bit right-shifting Galois LFSR with synchronous load.                   |
// |   clk      in   clock                                                      |
// |   load     in   load load_val this cycle (has priority over step)          |
// |   load_val in   16-bit value to load                                       |
// |   step     in   advance one state: q' = (q>>1) ^ (q[0] ? MASK : 0)         |
// |   q        out  current state                                              |
// | No reset port: the owner loads a known value while in reset.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lfsr16_galois #(
  parameter logic [15:0] MASK = 16'hB400
) (
  input  logic        clk,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        step,
  output logic [15:0] q
);

  logic [15:0] q_d;
  logic [15:0] q_q;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (step) begin
      q_d = (q_q >> 1) ^ (q_q[0] ? MASK : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/pattern_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pattern_writer                                                   |
// | Fills the banked pattern RAM with LFSR-drawn direction glyphs, then        |
// | replays the same LFSR sequence to read back and verify every entry.        |
// |   clk, rst   clock, synchronous active-high reset                          |
// |   start      fill request, honoured only in IDLE                           |
// |   seed       LFSR seed captured on accepted start (0 -> DEFAULT_SEED)      |
// |   busy       high while filling/verifying                                  |
// |   done       one-cycle completion pulse                                    |
// |   err        sticky readback mismatch flag                                 |
// |   mem_we/mem_addr/mem_din  RAM write/read port                             |
// |   mem_dout   RAM read data, one cycle after mem_addr                       |
// | BANKS*DEPTH must not exceed 2**AW.                                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pattern_writer #(
  parameter int          BANKS        = 4,
  parameter int          DEPTH        = 50,
  parameter int          AW           = 8,
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   seed,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [27:0]   mem_din,
  input  logic [27:0]   mem_dout
);

  import pattern_writer_pkg::*;

  localparam int            TOTAL     = BANKS * DEPTH;
  localparam logic [AW-1:0] LAST_ADDR = AW'(TOTAL - 1);

  pw_state_e           state_d, state_q;
  logic [AW-1:0]       addr_d, addr_q;
  logic [15:0]         seed_d, seed_q;
  logic [GLYPH_W-1:0]  exp_d, exp_q;
  logic                exp_vld_d, exp_vld_q;
  logic                err_d, err_q;
  logic                busy_d, busy_q;
  logic                done_d, done_q;

  logic                lfsr_load;
  logic [15:0]         lfsr_load_val;
  logic                lfsr_step;
  logic [15:0]         lfsr_q;
  logic [12:0]         lfsr_unused;

  logic [2:0]          code;
  logic                code_ok;
  logic [GLYPH_W-1:0]  glyph;
  logic [15:0]         eff_seed;

  // Reset loads DEFAULT_SEED so the LFSR is defined without its own reset.
  lfsr16_galois #(
    .MASK (LFSR_MASK)
  ) u_lfsr (
    .clk      (clk),
    .load     (rst | lfsr_load),
    .load_val (rst ? DEFAULT_SEED : lfsr_load_val),
    .step     (lfsr_step),
    .q        (lfsr_q)
  );

  // Only the low bits select a glyph; the rest is LFSR state.
  assign code        = lfsr_q[2:0];
  assign lfsr_unused = lfsr_q[15:3];
  assign code_ok     = code_is_valid(code);
  assign glyph       = glyph_of(code);
  assign eff_seed    = (seed == 16'h0000) ? DEFAULT_SEED : seed;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    seed_d        = seed_q;
    exp_d         = exp_q;
    exp_vld_d     = 1'b0;
    err_d         = err_q;
    lfsr_load     = 1'b0;
    lfsr_load_val = seed_q;
    lfsr_step     = 1'b0;
    mem_we        = 1'b0;
    mem_din       = '0;

    // Check the read issued in the previous cycle (VERIFY or DRAIN).
    if (exp_vld_q && (mem_dout != exp_q)) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          seed_d        = eff_seed;
          lfsr_load     = 1'b1;
          lfsr_load_val = eff_seed;
          err_d         = 1'b0;
          addr_d        = '0;
          state_d       = S_GEN;
        end
      end

      S_GEN: begin
        lfsr_step = 1'b1;
        if (code_ok) begin
          mem_we  = 1'b1;
          mem_din = glyph;
          if (addr_q == LAST_ADDR) begin
            // Rewind the generator so VERIFY sees the identical sequence.
            addr_d        = '0;
            lfsr_load     = 1'b1;
            lfsr_load_val = seed_q;
            state_d       = S_VERIFY;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end

      S_VERIFY: begin
        lfsr_step = 1'b1;
        if (code_ok) begin
          exp_d     = glyph;
          exp_vld_d = 1'b1;
          if (addr_q == LAST_ADDR) begin
            addr_d  = '0;
            state_d = S_DRAIN;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end

      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_GEN) || (state_d == S_VERIFY) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      seed_q    <= DEFAULT_SEED;
      exp_q     <= '0;
      exp_vld_q <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      seed_q    <= seed_d;
      exp_q     <= exp_d;
      exp_vld_q <= exp_vld_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // The write strobe and data are decoded from the registered state and
  // LFSR, so the RAM port reflects the code drawn in that very cycle; a
  // rejected draw leaves mem_we low while the address holds.
  assign mem_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
`default_nettype wire
